regfile_2r1w_clr: RTL and testbench
===================================

// Module: regfile_2r1w_clr
// PURPOSE
//  Parametrised register file: two read ports, one write port, per-byte write enables.
//  Optional write-to-read bypass and hard-wired zero register.
//  Sequenced clear after reset: one entry per cycle, so no wide single-cycle reset fan-out.
//  Serves as operand storage for the datapath; feeds two operand buses per cycle.
// PARAMETERS
//  A_WIDTH   5   address width; DEPTH = 2**A_WIDTH entries
//  D_WIDTH   32  data width; must be a multiple of 8
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
//  BYPASS    1   1: a read of the address written in the same cycle returns the new data; 0: returns old data
// PORTS
//  Clk     in   1          clock, all logic on rising edge
//  Rst     in   1          reset, synchronous, active-high
//  WEn     in   1          write enable
//  WAddr   in   A_WIDTH    write address
//  WData   in   D_WIDTH    write data
//  WBe     in   D_WIDTH/8  byte enables; bit i selects WData[8i+7:8i]
//  REnA    in   1          read enable, port A
//  RAddrA  in   A_WIDTH    read address, port A
//  RDataA  out  D_WIDTH    registered read data, port A
//  REnB    in   1          read enable, port B
//  RAddrB  in   A_WIDTH    read address, port B
//  RDataB  out  D_WIDTH    registered read data, port B
//  Busy    out  1          1 while the clear sequence runs; all accesses are ignored
// BEHAVIOUR
//  Reset:
//   - Rst is sampled at the clock edge; it wins over every other input.
//   - While Rst=1: state=CLEAR, clear pointer=0, RDataA=RDataB=0, Busy=1.
//  States:
//   - CLEAR: each cycle with Rst=0, writes 0 to entry[ptr] and increments ptr.
//     After entry DEPTH-1 is written, go to RUN. Busy=1 for exactly DEPTH cycles after Rst falls.
//   - RUN: Busy=0, normal access. Rst=1 at any point returns to CLEAR with ptr=0.
//   - Reset mid-clear restarts the clear from entry 0.
//  In CLEAR:
//   - WEn, REnA and REnB are ignored.
//   - RDataA and RDataB stay 0.
//  Write (RUN, WEn=1):
//   - At the edge, entry[WAddr] byte i is updated only where WBe[i]=1.
//   - WBe=0 leaves the entry unchanged.
//   - With ZERO_REG=1, a write to WAddr=0 is dropped.
//  Read (RUN):
//   - Latency 1 cycle: RDataX at edge N+1 reflects RAddrX sampled at edge N.
//   - REnX=0 at edge N gives RDataX=0 after that edge; the output is not held.
//   - ZERO_REG=1 with RAddrX=0 gives RDataX=0.
//  Same cycle WEn=1 and REnX=1 with WAddr==RAddrX (not a dropped zero-register write):
//   - BYPASS=1: RDataX = old entry with the enabled bytes replaced by WData.
//   - BYPASS=0: RDataX = old entry.
//  Ports A and B are independent: same or different addresses, any mix, all legal.
//  No width arithmetic other than ptr wrap; ptr is A_WIDTH bits and DEPTH-1 is the last value.
// STRUCTURE
//  Package regfile_pkg:
//   - state encoding {CLEAR, RUN}
//   - default A_WIDTH/D_WIDTH constants
//   - byte_merge(old, new, be) function, shared by the write path and the bypass path.
//  Sub-module regfile_clear_seq:
//   - holds the state register, ptr counter and Busy
//   - outputs clear write-enable and clear address to the storage array.
//  Top level: storage array, write-port mux (clear vs user), two read ports with bypass and zero-register logic.
// TESTING
//  1. Reset: Rst=1 for 2 cycles, then 0 -> Busy=1 for exactly 32 cycles, then 0; reads of every entry return 0.
//  2. Write then read: write 0xDEADBEEF to entry 5, WBe=4'hF; next cycle REnA=1, RAddrA=5 -> RDataA=0xDEADBEEF one cycle later.
//  3. Byte enables: entry 7 holds 0x11223344; write 0xAABBCCDD with WBe=4'b0101 -> entry 7 reads 0x11BB33DD.
//  4. Bypass:
//     - entry 9 holds 0; same cycle WEn=1, WAddr=9, WData=0x5A5A5A5A, WBe=4'hF, REnA=REnB=1, RAddrA=RAddrB=9.
//     - BYPASS=1: both ports return 0x5A5A5A5A. BYPASS=0: both return 0.
//  5. Zero register: write 0xFFFFFFFF to entry 0 -> a read of entry 0 returns 0 (ZERO_REG=1), or 0xFFFFFFFF (ZERO_REG=0).
//  6. Reset mid-clear and ignored accesses:
//     - Rst=1 during clear cycle 10 -> Busy stays 1 and runs 32 more cycles after Rst falls.
//     - WEn=1 (WData=0x12345678, WBe=4'hF) to entry 3 while Busy=1 is ignored: entry 3 reads 0 afterwards.
//     - Read while Busy returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file:
// state encoding, default widths and the byte-merge helper used by both
// the write path and the read bypass path.
package regfile_pkg;

  localparam int unsigned DEF_A_WIDTH  = 5;
  localparam int unsigned DEF_D_WIDTH  = 32;

  // Upper bound on data width supported by byte_merge; callers zero-extend
  // into this width and truncate the result back to their own width.
  localparam int unsigned MAX_D_WIDTH  = 1024;
  localparam int unsigned MAX_BE_WIDTH = MAX_D_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Replace the bytes of old_data selected by be with the matching bytes of new_data.
  function automatic logic [MAX_D_WIDTH-1:0] byte_merge(
    input logic [MAX_D_WIDTH-1:0]  old_data,
    input logic [MAX_D_WIDTH-1:0]  new_data,
    input logic [MAX_BE_WIDTH-1:0] be
  );
    logic [MAX_D_WIDTH-1:0] merged;
    merged = old_data;
    for (int i = 0; i < int'(MAX_BE_WIDTH); i++) begin
      if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_2r1w_clr_if.sv
// Access bus of the register file: one write port, two read ports, Busy.
//   master : drives write/read requests, receives read data and Busy
//   slave  : the register file itself
interface regfile_2r1w_clr_if #(
  parameter int unsigned A_WIDTH = regfile_pkg::DEF_A_WIDTH,
  parameter int unsigned D_WIDTH = regfile_pkg::DEF_D_WIDTH
);

  logic                   WEn;
  logic [A_WIDTH-1:0]     WAddr;
  logic [D_WIDTH-1:0]     WData;
  logic [D_WIDTH/8-1:0]   WBe;
  logic                   REnA;
  logic [A_WIDTH-1:0]     RAddrA;
  logic [D_WIDTH-1:0]     RDataA;
  logic                   REnB;
  logic [A_WIDTH-1:0]     RAddrB;
  logic [D_WIDTH-1:0]     RDataB;
  logic                   Busy;

  modport master (
    output WEn, WAddr, WData, WBe,
    output REnA, RAddrA, REnB, RAddrB,
    input  RDataA, RDataB, Busy
  );

  modport slave (
    input  WEn, WAddr, WData, WBe,
    input  REnA, RAddrA, REnB, RAddrB,
    output RDataA, RDataB, Busy
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, one per cycle, so the
// storage array needs no reset of its own.
//   Clk, Rst  : clock, synchronous active-high reset
//   busy      : registered, 1 while in CLEAR
//   clr_we_c  : clear write strobe for the current pointer (combinational)
//   clr_addr  : entry being cleared this cycle
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned A_WIDTH = DEF_A_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst,
  output logic               busy,
  output logic               clr_we_c,
  output logic [A_WIDTH-1:0] clr_addr
);

  localparam logic [A_WIDTH-1:0] LAST_PTR = {A_WIDTH{1'b1}};

  state_t             state;
  logic [A_WIDTH-1:0] ptr;

  // State, pointer and Busy; Rst has priority over everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + A_WIDTH'(1);
          if (ptr == LAST_PTR) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          busy <= 1'b0;
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // No clear write on a reset edge: the sequence restarts from entry 0.
  assign clr_we_c = (state == ST_CLEAR) && !Rst;
  assign clr_addr = ptr;

endmodule

// File: rtl/regfile_2r1w_clr.sv
// Register file, two registered read ports and one byte-enabled write port,
// with optional write-to-read bypass and hard-wired zero entry. Contents are
// zeroed by a one-entry-per-cycle sequence after reset.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : slave side of regfile_2r1w_clr_if (write, read A/B, Busy)
// D_WIDTH must be a multiple of 8 and no larger than regfile_pkg::MAX_D_WIDTH.
module regfile_2r1w_clr
  import regfile_pkg::*;
#(
  parameter int unsigned A_WIDTH  = DEF_A_WIDTH,
  parameter int unsigned D_WIDTH  = DEF_D_WIDTH,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                  Clk,
  input logic                  Rst,
  regfile_2r1w_clr_if.slave    bus
);

  localparam int unsigned DEPTH    = 1 << A_WIDTH;
  localparam int unsigned BE_WIDTH = D_WIDTH / 8;

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic               busy;
  logic               clr_we_c;
  logic [A_WIDTH-1:0] clr_addr;

  logic               wr_fire_c;
  logic [D_WIDTH-1:0] wr_merged_c;
  logic [D_WIDTH-1:0] rdata_a;
  logic [D_WIDTH-1:0] rdata_b;

  // Narrow wrapper around the package helper for this instance's widths.
  function automatic logic [D_WIDTH-1:0] merge(
    input logic [D_WIDTH-1:0]  old_data,
    input logic [D_WIDTH-1:0]  new_data,
    input logic [BE_WIDTH-1:0] be
  );
    return D_WIDTH'(byte_merge(MAX_D_WIDTH'(old_data),
                               MAX_D_WIDTH'(new_data),
                               MAX_BE_WIDTH'(be)));
  endfunction

  regfile_clear_seq #(
    .A_WIDTH (A_WIDTH)
  ) u_clear_seq (
    .Clk      (Clk),
    .Rst      (Rst),
    .busy     (busy),
    .clr_we_c (clr_we_c),
    .clr_addr (clr_addr)
  );

  // A user write takes effect only in RUN, outside reset, and never to a hard-wired zero entry.
  assign wr_fire_c   = bus.WEn && !busy && !Rst &&
                       !(ZERO_REG && (bus.WAddr == '0));
  assign wr_merged_c = merge(mem[bus.WAddr], bus.WData, bus.WBe);

  // Storage write port: clear sequencer has the port while busy.
  always_ff @(posedge Clk) begin
    if (clr_we_c) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire_c) begin
      mem[bus.WAddr] <= wr_merged_c;
    end
  end

  // Read port A.
  always_ff @(posedge Clk) begin
    if (Rst || busy || !bus.REnA) begin
      rdata_a <= '0;
    end else if (ZERO_REG && (bus.RAddrA == '0)) begin
      rdata_a <= '0;
    end else if (BYPASS && wr_fire_c && (bus.WAddr == bus.RAddrA)) begin
      rdata_a <= wr_merged_c;
    end else begin
      rdata_a <= mem[bus.RAddrA];
    end
  end

  // Read port B.
  always_ff @(posedge Clk) begin
    if (Rst || busy || !bus.REnB) begin
      rdata_b <= '0;
    end else if (ZERO_REG && (bus.RAddrB == '0)) begin
      rdata_b <= '0;
    end else if (BYPASS && wr_fire_c && (bus.WAddr == bus.RAddrB)) begin
      rdata_b <= wr_merged_c;
    end else begin
      rdata_b <= mem[bus.RAddrB];
    end
  end

  assign bus.RDataA = rdata_a;
  assign bus.RDataB = rdata_b;
  assign bus.Busy   = busy;

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Directed bench for regfile_2r1w_clr in its default configuration
// (A_WIDTH=5, D_WIDTH=32, ZERO_REG=1, BYPASS=1).
module tb_regfile_2r1w_clr;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wbe;
    logic          rena;
    logic [AW-1:0] raddra;
    logic          renb;
    logic [AW-1:0] raddrb;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  logic Clk;
  logic Rst;

  int vectors;
  int miscompares;

  regfile_2r1w_clr_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  regfile_2r1w_clr dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.WEn    = 1'b0;
    bus.WAddr  = '0;
    bus.WData  = '0;
    bus.WBe    = '0;
    bus.REnA   = 1'b0;
    bus.RAddrA = '0;
    bus.REnB   = 1'b0;
    bus.RAddrB = '0;
  endtask

  // Count clock edges until Busy drops; bounded so a stuck Busy still ends the run.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.Busy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  vec_t vecs [13];
  int   cnt;
  logic rd_zero_ok;

  initial begin
    vectors     = 0;
    miscompares = 0;

    //           wen   waddr  wdata          wbe      rena  ra     renb  rb     exp_a          exp_b
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF,    1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd5,  1'b0, 5'd0,  32'hDEADBEEF,  32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h11223344, 4'hF,    1'b0, 5'd0,  1'b1, 5'd5,  32'h0,         32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd7,  32'hAABBCCDD, 4'b0101, 1'b1, 5'd7,  1'b1, 5'd7,  32'h11BB33DD,  32'h11BB33DD};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd7,  1'b1, 5'd5,  32'h11BB33DD,  32'hDEADBEEF};
    vecs[5]  = '{1'b1, 5'd9,  32'h5A5A5A5A, 4'hF,    1'b1, 5'd9,  1'b1, 5'd9,  32'h5A5A5A5A,  32'h5A5A5A5A};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd9,  1'b0, 5'd9,  32'h5A5A5A5A,  32'h0};
    vecs[7]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF,    1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd0,  1'b1, 5'd9,  32'h0,         32'h5A5A5A5A};
    vecs[9]  = '{1'b1, 5'd5,  32'h12345678, 4'h0,    1'b1, 5'd5,  1'b1, 5'd7,  32'hDEADBEEF,  32'h11BB33DD};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF,  32'hDEADBEEF};
    vecs[11] = '{1'b1, 5'd31, 32'hCAFEF00D, 4'b1100, 1'b1, 5'd31, 1'b1, 5'd30, 32'hCAFE0000,  32'h0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd31, 1'b1, 5'd31, 32'hCAFE0000,  32'hCAFE0000};

    idle();

    // Reset and full clear sequence.
    Rst = 1'b1;
    bus.REnA = 1'b1; bus.RAddrA = 5'd5;
    tick();
    tick();
    check("reset_busy", 32'(bus.Busy), 32'd1);
    check("reset_rdata_a", bus.RDataA, 32'h0);
    check("reset_rdata_b", bus.RDataB, 32'h0);
    Rst = 1'b0;
    idle();
    count_busy(cnt);
    check("clear_busy_cycles", 32'(cnt), 32'd32);

    // Every entry reads back 0 after the clear.
    for (int i = 0; i < 32; i++) begin
      bus.REnA = 1'b1; bus.RAddrA = AW'(i);
      bus.REnB = 1'b1; bus.RAddrB = AW'(31 - i);
      tick();
      check($sformatf("cleared_a[%0d]", i), bus.RDataA, 32'h0);
      check($sformatf("cleared_b[%0d]", 31 - i), bus.RDataB, 32'h0);
    end
    idle();
    tick();

    // Table-driven write/read/bypass/zero-register vectors.
    for (int v = 0; v < 13; v++) begin
      bus.WEn    = vecs[v].wen;
      bus.WAddr  = vecs[v].waddr;
      bus.WData  = vecs[v].wdata;
      bus.WBe    = vecs[v].wbe;
      bus.REnA   = vecs[v].rena;
      bus.RAddrA = vecs[v].raddra;
      bus.REnB   = vecs[v].renb;
      bus.RAddrB = vecs[v].raddrb;
      tick();
      check($sformatf("vec%0d_a", v), bus.RDataA, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), bus.RDataB, vecs[v].exp_b);
      check($sformatf("vec%0d_busy", v), 32'(bus.Busy), 32'd0);
    end
    idle();
    tick();

    // Reset during clear cycle 10 restarts the sequence; accesses while busy are ignored.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midclear_busy", 32'(bus.Busy), 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    cnt = 0;
    rd_zero_ok = 1'b1;
    bus.REnA = 1'b1; bus.RAddrA = 5'd5;
    while (bus.Busy === 1'b1 && cnt < 200) begin
      if (cnt == 20) begin
        bus.WEn = 1'b1; bus.WAddr = 5'd3; bus.WData = 32'h12345678; bus.WBe = 4'hF;
      end else begin
        bus.WEn = 1'b0;
      end
      tick();
      cnt++;
      if (bus.RDataA !== 32'h0) rd_zero_ok = 1'b0;
    end
    check("restart_busy_cycles", 32'(cnt), 32'd32);
    check("read_while_busy_zero", 32'(rd_zero_ok), 32'd1);
    idle();
    bus.REnA = 1'b1; bus.RAddrA = 5'd3;
    bus.REnB = 1'b1; bus.RAddrB = 5'd5;
    tick();
    check("ignored_write_entry3", bus.RDataA, 32'h0);
    check("recleared_entry5", bus.RDataB, 32'h0);

    // Read enable low drops the output rather than holding it.
    idle();
    bus.WEn = 1'b1; bus.WAddr = 5'd12; bus.WData = 32'h0BADF00D; bus.WBe = 4'hF;
    tick();
    bus.WEn = 1'b0;
    bus.REnA = 1'b1; bus.RAddrA = 5'd12;
    tick();
    check("ren_read_12", bus.RDataA, 32'h0BADF00D);
    bus.REnA = 1'b0;
    tick();
    check("ren_low_not_held", bus.RDataA, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
